// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: opcode constants, the NOP word and the fetch FSM
// state encoding shared by fetch_stage and its IF/ID register.
package fetch_stage_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, stall and flush controls.
// Ports: clk, rst, flush_i, load_i, stall_i, pc_i, instr_i -> valid_o, pc_o, instr_o, opcode_o.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic [6:0]      opcode_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;

    // Flush beats load; an unstalled valid entry is consumed by decode.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (!stall_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o  = valid_q;
    assign pc_o     = pc_q;
    assign instr_o  = instr_q;
    assign opcode_o = valid_q ? instr_q[6:0] : 7'b0;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC + one-outstanding imem fetch FSM feeding the IF/ID register.
// Ports: clk, rst, redirect_*, id_stall, imem_req_*, imem_resp_*, if_id_*;
// macro FETCH_PERF_EN adds perf_fetch_count / perf_flush_count.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic [6:0]      if_id_opcode
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_count,
    output logic [31:0]     perf_flush_count
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     hold_instr_q, hold_instr_d;

    logic            accept;
    logic            in_flight;
    logic            ld;
    logic [XLEN-1:0] ld_pc;
    logic [31:0]     ld_instr;

    assign accept = !if_id_valid || !id_stall;

    // A response arriving this cycle retires the request, so only a
    // request still unanswered after this edge needs draining.
    assign in_flight = (state_q == S_REQ && imem_req_ready)
                    || ((state_q == S_WAIT || state_q == S_DRAIN)
                        && !imem_resp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (accept) begin
                        state_d = S_REQ;
                    end else begin
                        hold_pc_d    = req_pc_q;
                        hold_instr_d = imem_resp_data;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!id_stall) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Leaving S_HOLD is what empties the hold buffer.
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~XLEN'(3);
            state_d = in_flight ? S_DRAIN : S_REQ;
        end
    end

    always_comb begin
        imem_req_valid = (state_q == S_REQ);
        ld             = 1'b0;
        ld_pc          = req_pc_q;
        ld_instr       = imem_resp_data;
        if (state_q == S_WAIT && imem_resp_valid && accept) begin
            ld = !redirect_valid;
        end
        if (state_q == S_HOLD && !id_stall) begin
            ld       = !redirect_valid;
            ld_pc    = hold_pc_q;
            ld_instr = hold_instr_q;
        end
    end

    assign imem_req_addr = pc_q;

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (redirect_valid),
        .load_i   (ld),
        .stall_i  (id_stall),
        .pc_i     (ld_pc),
        .instr_i  (ld_instr),
        .valid_o  (if_id_valid),
        .pc_o     (if_id_pc),
        .instr_o  (if_id_instr),
        .opcode_o (if_id_opcode)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (ld) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_fetch_count = perf_fetch_q;
    assign perf_flush_count = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a bench-side
// memory and an instruction-stream model of the IF/ID contents.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_flush_count;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN(64),
        .RESET_PC(RST_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_stall        (id_stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .if_id_opcode    (if_id_opcode)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_count(perf_fetch_count),
        .perf_flush_count(perf_flush_count)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        int          seq;
    } ent_t;

    ent_t        expq[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_addr = RST_PC;
    bit          busy = 0;
    bit          killed = 0;
    logic [63:0] slot_addr = '0;
    int          cnt = 0;
    int          lat = 1;
    int          seq_n = 0;
    int          last_seq = -1;
    int          m_loads = 0;
    int          m_flushes = 0;
    bit          run_cmp = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [6:0] opc;
        case (int'((a >> 2) % 64'd5))
            0:       opc = 7'b0110011;
            1:       opc = 7'b0010011;
            2:       opc = 7'b0000011;
            3:       opc = 7'b0100011;
            default: opc = 7'b1100011;
        endcase
        return {a[26:2], opc};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Stream model: responses not overtaken by a redirect or reset join
    // the queue; its head is what IF/ID must show.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            expq.delete();
            exp_addr  = RST_PC;
            m_loads   = 0;
            m_flushes = 0;
            if (imem_resp_valid) busy = 0;
            else if (busy) killed = 1;
        end else begin
            if (redirect_valid) begin
                expq.delete();
                m_flushes++;
            end else if (expq.size() > 0 && !id_stall) begin
                void'(expq.pop_front());
            end
            if (imem_resp_valid) begin
                if (!killed && !redirect_valid) begin
                    expq.push_back('{pc: slot_addr,
                                     instr: mem_word(slot_addr),
                                     seq: seq_n});
                    seq_n++;
                end
                busy = 0;
            end else if (busy && redirect_valid) begin
                killed = 1;
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_addr);
                chk("one_outstanding", {63'b0, busy}, 64'd0);
                busy      = 1;
                killed    = redirect_valid;
                slot_addr = imem_req_addr;
                cnt       = lat;
                exp_addr  = exp_addr + 64'd4;
            end
            if (redirect_valid) exp_addr = redirect_pc & ~64'h3;
            if (expq.size() > 0 && expq[0].seq != last_seq) begin
                m_loads++;
                last_seq = expq[0].seq;
            end
        end
    end

    // Memory: answers the accepted request lat cycles after acceptance.
    initial forever begin
        @(negedge clk);
        imem_resp_valid = 1'b0;
        if (busy) begin
            if (cnt <= 1) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(slot_addr);
            end else begin
                cnt--;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (run_cmp && !rst) begin
            if (expq.size() > 0) begin
                chk("ifid_word", {if_id_valid, if_id_opcode, if_id_instr},
                    {1'b1, expq[0].instr[6:0], expq[0].instr});
                chk("ifid_pc", if_id_pc, expq[0].pc);
            end else begin
                chk("ifid_empty", {if_id_valid, if_id_opcode}, 64'd0);
            end
            if (expq.size() == 2) chk("no_req_in_hold", imem_req_valid, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1; redirect_valid = 0; redirect_pc = '0;
        id_stall = 0; imem_req_ready = 1;
        repeat (3) @(negedge clk);
        run_cmp = 1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_ifid_valid", if_id_valid, 0);
        chk("rst_ifid_pc", if_id_pc, 0);
        chk("rst_ifid_instr", if_id_instr, 32'h13);
        chk("rst_opcode", if_id_opcode, 0);
        rst = 0;
        @(negedge clk);
        chk("req0_valid", imem_req_valid, 1);
        chk("req0_addr", imem_req_addr, 64'h100);
        @(negedge clk);
        chk("wait_no_req", imem_req_valid, 0);
        @(negedge clk);
        chk("i0_pc", if_id_pc, 64'h100);
        chk("i0_instr", if_id_instr, 32'h2063);
        chk("i0_opcode", if_id_opcode, 7'h63);
        chk("req1_addr", imem_req_addr, 64'h104);
        id_stall = 1;
        @(negedge clk);
        chk("stall_pc", if_id_pc, 64'h100);
        repeat (3) begin
            @(negedge clk);
            chk("hold_no_req", imem_req_valid, 0);
        end
        @(negedge clk);
        chk("hold_pc", if_id_pc, 64'h100);
        id_stall = 0;
        @(negedge clk);
        chk("i1_pc", if_id_pc, 64'h104);
        chk("i1_opcode", if_id_opcode, 7'h33);
        chk("req2_addr", imem_req_addr, 64'h108);
        @(negedge clk);
        @(negedge clk);
        chk("i2_instr", if_id_instr, 32'h2113);
        chk("req3_addr", imem_req_addr, 64'h10C);
        lat = 3;
        id_stall = 1;
        @(negedge clk);
        chk("pre_redir_valid", if_id_valid, 1);
        redirect_valid = 1; redirect_pc = 64'h200;
        @(negedge clk);
        redirect_valid = 0; id_stall = 0; lat = 1;
        chk("redir_flush", if_id_valid, 0);
        chk("drain_no_req", imem_req_valid, 0);
        @(negedge clk);
        chk("drain_no_req2", imem_req_valid, 0);
        @(negedge clk);
        chk("redir_req_addr", imem_req_addr, 64'h200);
        @(negedge clk);
        @(negedge clk);
        chk("t200_pc", if_id_pc, 64'h200);
        redirect_valid = 1; redirect_pc = 64'h203;
        @(negedge clk);
        redirect_valid = 0;
        chk("drain2_no_req", imem_req_valid, 0);
        @(negedge clk);
        chk("align_addr", imem_req_addr, 64'h200);
        @(negedge clk);
        redirect_valid = 1; redirect_pc = 64'h300;
        @(negedge clk);
        redirect_valid = 0;
        chk("same_cycle_flush", if_id_valid, 0);
        chk("same_cycle_req", {imem_req_valid, imem_req_addr[62:0]},
            {1'b1, 63'h300});
        repeat (8) @(negedge clk);
`ifdef FETCH_PERF_EN
        chk("perf_flush", perf_flush_count, 3);
        chk("perf_fetch", perf_fetch_count, m_loads);
`endif
        n = 0;
        while (!imem_req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("req_before_rst", imem_req_valid, 1);
        lat = 4;
        @(negedge clk);
        rst = 1; imem_req_ready = 0; lat = 1;
        repeat (2) @(negedge clk);
        chk("rst2_ifid_valid", if_id_valid, 0);
        chk("rst2_req_valid", imem_req_valid, 0);
        chk("rst2_instr", if_id_instr, 32'h13);
`ifdef FETCH_PERF_EN
        chk("rst2_perf", {perf_fetch_count, perf_flush_count}, 0);
`endif
        rst = 0;
        @(negedge clk);
        chk("late_resp_ignored", if_id_valid, 0);
        chk("post_rst_addr", {imem_req_valid, imem_req_addr[62:0]},
            {1'b1, 63'h100});
        @(negedge clk);
        imem_req_ready = 1;
        n = 0;
        while (!if_id_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_ifid_pc", if_id_pc, 64'h100);
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
